dma_wrr_arbiter: RTL and testbench
==================================

# dma_wrr_arbiter

Weighted round-robin arbiter for the DMA channel front end. It sits between the per-channel request logic and the shared bus master, and grants one channel per accepted transfer slot. Each channel may hold up to a programmable number of consecutive grants before rotation. Grants are registered, carried on a valid/ready handshake, and held stable until the downstream master accepts them.

## Interface
Parameters:
- REQ_NUM, default 4: number of requesting channels; legal values are 2 or more.
- WEIGHT_W, default 4: width of each channel's weight and credit counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- reqs_i  in  REQ_NUM  per-channel request level; bit i belongs to channel i.
- weights_i  in  REQ_NUM*WEIGHT_W  channel i weight in bits [i*WEIGHT_W +: WEIGHT_W]; a value of 0 is treated as 1.
- gnt_ready_i  in  1  downstream accepts the current grant.
- gnt_valid_o  out  1  a grant is pending.
- gnts_o  out  REQ_NUM  one-hot grant; all zero when gnt_valid_o=0.
- gnt_id_o  out  $clog2(REQ_NUM)  binary index of the granted channel; 0 when idle.

## Operation
- State:
  - ptr: index of the last winner.
  - cnt[i]: WEIGHT_W-bit credit for channel i.
  - Output registers: gnt_valid_o, gnts_o, gnt_id_o.
- Effective weight: ew[i] = (weights_i[i]==0) ? 1 : weights_i[i].
- Eligibility: elig = reqs_i & (cnt!=0).
- Arbitration happens only in an "issue slot", defined as gnt_valid_o==0 or (gnt_valid_o & gnt_ready_i).
- In an issue slot, when reqs_i!=0:
  - Normal pick, when elig!=0: winner is the first set bit of elig, scanning ascending from ptr and wrapping. The holder keeps the grant while it still has credit. cnt[winner] decrements by 1.
  - Reload pick, when elig==0: winner is the first set bit of reqs_i, scanning ascending from ptr+1 modulo REQ_NUM. Every cnt[i] loads ew[i], and the winner loads ew[winner]-1.
  - ptr loads winner. gnt_valid_o goes to 1, gnts_o loads the one-hot winner, gnt_id_o loads the winner index.
- In an issue slot with reqs_i==0: gnt_valid_o, gnts_o and gnt_id_o clear. ptr and cnt hold.
- Outside an issue slot (valid high, ready low): all state holds.
  - The grant is never retracted or changed, even if reqs_i drops or changes.
  - weights_i is sampled only on a reload.
- Credit arithmetic is unsigned and saturating at 0. No path increments a counter beyond a loaded weight.

## Timing
- Reset values:
  - gnt_valid_o=0, gnts_o=0, gnt_id_o=0.
  - ptr=REQ_NUM-1, all cnt=0.
  - As a result, the first grant after reset is a reload pick starting at channel 0.
- Latency: a request sampled at edge N in an issue slot appears as a grant after edge N, i.e. 1 cycle.
- Throughput: with gnt_ready_i held at 1 and requests present, a new grant is issued every cycle.
- Handshake: a transfer occurs on an edge where gnt_valid_o=1 and gnt_ready_i=1. gnt_ready_i may be high while valid is low; that cycle has no effect beyond being an issue slot.
- Asserting rstn_i mid-grant clears the outputs immediately, without waiting for a clock edge. Release of reset is synchronous to clk_i; no grant is issued before the first edge after release.

## Configuration
- Macro DMA_ARB_URGENT_EN, when defined:
  - Adds input urgent_i [REQ_NUM].
  - When (reqs_i & urgent_i)!=0 in an issue slot, the pick is restricted to those channels, scanning ascending from ptr+1 and wrapping.
  - An urgent pick neither reloads nor decrements any cnt, but it does update ptr.
  - Non-urgent arbitration resumes unchanged once no urgent request is present.
- When undefined: the port is absent and behaviour is exactly as described above.

## Test plan
- Reset, then reqs_i=4'b1111, weights 2,1,1,1, gnt_ready_i=1 -> gnt_id_o sequence 0,0,1,2,3,0,0,1,2,3; gnt_valid_o high from the first edge after the request.
- Grant channel 2 with gnt_ready_i=0 for 5 cycles while reqs_i changes to 4'b0001 -> gnts_o holds 4'b0100 for all 5 cycles; after ready, the next grant is channel 0.
- Weight 0 on all channels, reqs_i=4'b1010 -> alternating grants 1,3,1,3.
- reqs_i=0 after a grant is accepted -> gnt_valid_o=0, gnts_o=0 the next cycle; ptr and cnt unchanged, checked by the next pick continuing the sequence.
- rstn_i asserted while gnt_valid_o=1 -> outputs are 0 before the next edge; after release, the first grant is the lowest requesting channel.
- With DMA_ARB_URGENT_EN defined, weights 3,1,1,1, all requesting, urgent_i=4'b1000 for 2 cycles -> grants 3,3, then resume at channel 0 with a full credit of 3.

Source files
------------

// File: rtl/dma_wrr_arbiter.sv
// Weighted round-robin grant arbiter for the DMA channel front end.
// Optional urgent-request override is compiled in with DMA_ARB_URGENT_EN.
module dma_wrr_arbiter #(
  parameter int unsigned REQ_NUM  = 4,
  parameter int unsigned WEIGHT_W = 4
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic [REQ_NUM-1:0]            reqs_i,
  input  logic [REQ_NUM*WEIGHT_W-1:0]   weights_i,
`ifdef DMA_ARB_URGENT_EN
  input  logic [REQ_NUM-1:0]            urgent_i,
`endif
  input  logic                          gnt_ready_i,
  output logic                          gnt_valid_o,
  output logic [REQ_NUM-1:0]            gnts_o,
  output logic [$clog2(REQ_NUM)-1:0]    gnt_id_o
);

  localparam int unsigned     IDW  = $clog2(REQ_NUM);
  localparam logic [IDW-1:0]  LAST = IDW'(REQ_NUM - 1);
  localparam logic [WEIGHT_W-1:0] ONE = {{(WEIGHT_W-1){1'b0}}, 1'b1};

  logic [IDW-1:0]      ptr;
  logic [IDW-1:0]      ptr_inc;
  logic [WEIGHT_W-1:0] cnt [REQ_NUM];
  logic [WEIGHT_W-1:0] ew  [REQ_NUM];
  logic [REQ_NUM-1:0]  elig;
  logic [REQ_NUM-1:0]  urg;
  logic                issue;
  logic                urgent_pick;
  logic                reload_pick;
  logic [IDW-1:0]      win;
  logic [REQ_NUM-1:0]  win_oh;

  // First set bit of v scanning upward from start, wrapping at REQ_NUM.
  function automatic logic [IDW-1:0] scan(input logic [REQ_NUM-1:0] v,
                                          input logic [IDW-1:0]     start);
    logic [IDW-1:0] r;
    logic [IDW:0]   idx;
    logic           hit;
    r   = '0;
    hit = 1'b0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      idx = {1'b0, start} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(REQ_NUM)) idx = idx - (IDW+1)'(REQ_NUM);
      if (!hit && v[idx[IDW-1:0]]) begin
        hit = 1'b1;
        r   = idx[IDW-1:0];
      end
    end
    return r;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      ew[i] = weights_i[i*WEIGHT_W +: WEIGHT_W];
      if (ew[i] == '0) ew[i] = ONE;
      elig[i] = reqs_i[i] && (cnt[i] != '0);
    end
  end

  always_comb begin
`ifdef DMA_ARB_URGENT_EN
    urg = reqs_i & urgent_i;
`else
    urg = '0;
`endif
    issue       = !gnt_valid_o || gnt_ready_i;
    ptr_inc     = (ptr == LAST) ? '0 : ptr + 1'b1;
    urgent_pick = (urg != '0);
    reload_pick = !urgent_pick && (elig == '0);
    if (urgent_pick)      win = scan(urg, ptr_inc);
    else if (reload_pick) win = scan(reqs_i, ptr_inc);
    else                  win = scan(elig, ptr);
    win_oh = {{(REQ_NUM-1){1'b0}}, 1'b1} << win;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      gnt_valid_o <= 1'b0;
      gnts_o      <= '0;
      gnt_id_o    <= '0;
      ptr         <= LAST;
      for (int unsigned i = 0; i < REQ_NUM; i++) cnt[i] <= '0;
    end else if (issue) begin
      if (reqs_i != '0) begin
        gnt_valid_o <= 1'b1;
        gnts_o      <= win_oh;
        gnt_id_o    <= win;
        ptr         <= win;
        // Urgent picks leave credits untouched so normal rotation resumes intact.
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
          if (!urgent_pick) begin
            if (reload_pick)
              cnt[i] <= win_oh[i] ? ew[i] - ONE : ew[i];
            else if (win_oh[i] && cnt[i] != '0)
              cnt[i] <= cnt[i] - ONE;
          end
        end
      end else begin
        gnt_valid_o <= 1'b0;
        gnts_o      <= '0;
        gnt_id_o    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dma_wrr_arbiter.sv
// Directed self-checking bench for dma_wrr_arbiter (REQ_NUM=4, WEIGHT_W=4).
module tb_dma_wrr_arbiter;

  logic        clk;
  logic        rstn;
  logic [3:0]  reqs;
  logic [15:0] weights;
  logic [3:0]  urgent;
  logic        ready;
  logic        gnt_valid;
  logic [3:0]  gnts;
  logic [1:0]  gnt_id;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  dma_wrr_arbiter #(.REQ_NUM(4), .WEIGHT_W(4)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .reqs_i      (reqs),
    .weights_i   (weights),
`ifdef DMA_ARB_URGENT_EN
    .urgent_i    (urgent),
`endif
    .gnt_ready_i (ready),
    .gnt_valid_o (gnt_valid),
    .gnts_o      (gnts),
    .gnt_id_o    (gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    reqs = '0; weights = '0; urgent = '0; ready = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    total_cnt++;
    if ({gnt_valid, gnts, gnt_id} !== 7'b0)
      $display("FAIL reset_outputs: got v=%b g=%b id=%0d expected all 0", gnt_valid, gnts, gnt_id);
    else pass_cnt++;
    @(negedge clk);
    rstn = 1'b1;
    reqs = '0; ready = 1'b1;
    tick();
    total_cnt++;
    if ({gnt_valid, gnts, gnt_id} !== 7'b0)
      $display("FAIL reset_idle: got v=%b g=%b id=%0d expected all 0", gnt_valid, gnts, gnt_id);
    else pass_cnt++;
  endtask

  task automatic test_weighted_rotation();
    logic [1:0] seq [10] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [3:0] oh;
    apply_reset();
    weights = 16'h1112;
    reqs    = 4'b1111;
    ready   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      oh = 4'b0001 << seq[i];
      total_cnt++;
      if ({gnt_valid, gnts, gnt_id} !== {1'b1, oh, seq[i]})
        $display("FAIL wrr_seq[%0d]: got v=%b g=%b id=%0d expected v=1 g=%b id=%0d",
                 i, gnt_valid, gnts, gnt_id, oh, seq[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold_stall();
    apply_reset();
    weights = 16'h1111;
    reqs    = 4'b0100;
    ready   = 1'b1;
    tick();
    total_cnt++;
    if ({gnt_valid, gnts, gnt_id} !== {1'b1, 4'b0100, 2'd2})
      $display("FAIL hold_first: got v=%b g=%b id=%0d expected v=1 g=0100 id=2", gnt_valid, gnts, gnt_id);
    else pass_cnt++;
    ready = 1'b0;
    reqs  = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if ({gnt_valid, gnts, gnt_id} !== {1'b1, 4'b0100, 2'd2})
        $display("FAIL hold_stall[%0d]: got v=%b g=%b id=%0d expected v=1 g=0100 id=2",
                 i, gnt_valid, gnts, gnt_id);
      else pass_cnt++;
    end
    ready = 1'b1;
    tick();
    total_cnt++;
    if ({gnt_valid, gnts, gnt_id} !== {1'b1, 4'b0001, 2'd0})
      $display("FAIL hold_release: got v=%b g=%b id=%0d expected v=1 g=0001 id=0", gnt_valid, gnts, gnt_id);
    else pass_cnt++;
  endtask

  task automatic test_zero_weight();
    logic [1:0] seq [4] = '{2'd1, 2'd3, 2'd1, 2'd3};
    apply_reset();
    weights = 16'h0000;
    reqs    = 4'b1010;
    ready   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (gnt_valid !== 1'b1 || gnt_id !== seq[i])
        $display("FAIL zero_weight[%0d]: got v=%b id=%0d expected v=1 id=%0d", i, gnt_valid, gnt_id, seq[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_idle_gap();
    logic [1:0] pre  [3] = '{2'd0, 2'd0, 2'd1};
    logic [1:0] post [3] = '{2'd2, 2'd3, 2'd0};
    apply_reset();
    weights = 16'h1112;
    reqs    = 4'b1111;
    ready   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (gnt_valid !== 1'b1 || gnt_id !== pre[i])
        $display("FAIL idle_pre[%0d]: got v=%b id=%0d expected v=1 id=%0d", i, gnt_valid, gnt_id, pre[i]);
      else pass_cnt++;
    end
    reqs = 4'b0000;
    tick();
    total_cnt++;
    if ({gnt_valid, gnts, gnt_id} !== 7'b0)
      $display("FAIL idle_clear: got v=%b g=%b id=%0d expected all 0", gnt_valid, gnts, gnt_id);
    else pass_cnt++;
    reqs = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (gnt_valid !== 1'b1 || gnt_id !== post[i])
        $display("FAIL idle_post[%0d]: got v=%b id=%0d expected v=1 id=%0d", i, gnt_valid, gnt_id, post[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    weights = 16'h1111;
    reqs    = 4'b1000;
    ready   = 1'b1;
    tick();
    ready = 1'b0;
    total_cnt++;
    if ({gnt_valid, gnts, gnt_id} !== {1'b1, 4'b1000, 2'd3})
      $display("FAIL areset_pre: got v=%b g=%b id=%0d expected v=1 g=1000 id=3", gnt_valid, gnts, gnt_id);
    else pass_cnt++;
    #1;
    rstn = 1'b0;
    #1;
    total_cnt++;
    if ({gnt_valid, gnts, gnt_id} !== 7'b0)
      $display("FAIL areset_immediate: got v=%b g=%b id=%0d expected all 0", gnt_valid, gnts, gnt_id);
    else pass_cnt++;
    reqs  = 4'b0110;
    ready = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    total_cnt++;
    if (gnt_valid !== 1'b0)
      $display("FAIL areset_release_idle: got v=%b expected v=0", gnt_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({gnt_valid, gnts, gnt_id} !== {1'b1, 4'b0010, 2'd1})
      $display("FAIL areset_first_grant: got v=%b g=%b id=%0d expected v=1 g=0010 id=1", gnt_valid, gnts, gnt_id);
    else pass_cnt++;
  endtask

`ifdef DMA_ARB_URGENT_EN
  task automatic test_urgent();
    logic [1:0] seq [6] = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1};
    apply_reset();
    weights = 16'h1113;
    reqs    = 4'b1111;
    ready   = 1'b1;
    urgent  = 4'b1000;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 1) urgent = 4'b0000;
      total_cnt++;
      if (gnt_valid !== 1'b1 || gnt_id !== seq[i])
        $display("FAIL urgent[%0d]: got v=%b id=%0d expected v=1 id=%0d", i, gnt_valid, gnt_id, seq[i]);
      else pass_cnt++;
    end
  endtask
`endif

  initial begin
    rstn = 1'b1; reqs = '0; weights = '0; urgent = '0; ready = 1'b0;
    test_reset();
    test_weighted_rotation();
    test_hold_stall();
    test_zero_weight();
    test_idle_gap();
    test_async_reset();
`ifdef DMA_ARB_URGENT_EN
    test_urgent();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
